// File: rtl/nn_pkg.sv
// -----------------------------------------------------------------------------
// nn_pkg
// Shared constants and types for the neural-network layer datapath.
//   ACC_W / OUT_W / FRAC_SHIFT : accumulator width (Q24.16), stored width
//                                (Q8.8) and the shift between the two.
//   Q_OUT_MAX / Q_OUT_MIN      : signed saturation limits of a stored result.
//   seq_state_t                : layer sequencer FSM states.
// -----------------------------------------------------------------------------
package nn_pkg;

   localparam int ACC_W      = 40;
   localparam int OUT_W      = 16;
   localparam int FRAC_SHIFT = 8;

   localparam logic [OUT_W-1:0] Q_OUT_MAX = 16'h7FFF;
   localparam logic [OUT_W-1:0] Q_OUT_MIN = 16'h8000;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LAUNCH = 3'd1,
      ST_WAIT   = 3'd2,
      ST_STORE  = 3'd3,
      ST_FINISH = 3'd4
   } seq_state_t;

endpackage

// File: rtl/nn_quantize.sv
// -----------------------------------------------------------------------------
// nn_quantize
// Combinational requantizer: arithmetic shift right, saturate to the signed
// output range, then optionally clamp negatives to zero.
//   acc_i : signed accumulator, ACC_W bits
//   q_o   : quantized result, OUT_W bits
// -----------------------------------------------------------------------------
module nn_quantize #(
   parameter int ACC_W      = nn_pkg::ACC_W,
   parameter int OUT_W      = nn_pkg::OUT_W,
   parameter int FRAC_SHIFT = nn_pkg::FRAC_SHIFT,
   parameter int RELU_EN    = 1
) (
   input  logic signed [ACC_W-1:0] acc_i,
   output logic        [OUT_W-1:0] q_o
);

   // Output range limits expressed at accumulator width for the compare.
   localparam logic signed [ACC_W-1:0] HI_L = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] LO_L = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   logic signed [ACC_W-1:0] shifted_s;
   logic        [OUT_W-1:0] sat_s;

   // Shift, saturate and optional ReLU.
   always_comb begin
      shifted_s = acc_i >>> FRAC_SHIFT;
      if (shifted_s > HI_L) begin
         sat_s = {1'b0, {(OUT_W-1){1'b1}}};
      end else if (shifted_s < LO_L) begin
         sat_s = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
         sat_s = shifted_s[OUT_W-1:0];
      end
      if ((RELU_EN != 0) && sat_s[OUT_W-1]) begin
         q_o = '0;
      end else begin
         q_o = sat_s;
      end
   end

endmodule

// File: rtl/layer_sequencer.sv
// -----------------------------------------------------------------------------
// layer_sequencer
// Runs one fully-connected layer on the shared neuron MAC datapath, one output
// neuron at a time, stores quantized results and tracks the arg-max class.
//   clk, rst_n         : clock; synchronous active-low reset
//   start / busy / done: host handshake (done is a one-cycle pulse)
//   class_idx/_valid   : index of the largest raw accumulator of the last layer
//   neuron_start/_sel  : datapath start pulse and weight-bank select
//   neuron_done/_dout  : datapath completion and accumulator
//   rd_addr / rd_data  : result buffer read port, one cycle latency
// -----------------------------------------------------------------------------
module layer_sequencer #(
   parameter  int NUM_NEURONS = 10,
   parameter  int ACC_W       = nn_pkg::ACC_W,
   parameter  int OUT_W       = nn_pkg::OUT_W,
   parameter  int FRAC_SHIFT  = nn_pkg::FRAC_SHIFT,
   parameter  int RELU_EN     = 1,
   localparam int IW          = $clog2(NUM_NEURONS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [IW-1:0]    class_idx,
   output logic             class_valid,
   output logic             neuron_start,
   output logic [IW-1:0]    neuron_sel,
   input  logic             neuron_done,
   input  logic [ACC_W-1:0] neuron_dout,
   input  logic [IW-1:0]    rd_addr,
   output logic [OUT_W-1:0] rd_data
);
   import nn_pkg::*;

   localparam logic [IW-1:0] LAST_SEL = IW'(NUM_NEURONS - 1);

   seq_state_t               state_q;
   logic        [IW-1:0]     sel_q;
   logic signed [ACC_W-1:0]  cap_q;
   logic signed [ACC_W-1:0]  best_q;
   logic        [IW-1:0]     class_idx_q;
   logic                     class_valid_q;
   logic                     busy_q;
   logic                     done_q;
   logic                     nstart_q;
   logic        [OUT_W-1:0]  rd_data_q;
   logic        [OUT_W-1:0]  buf_q [NUM_NEURONS];
   logic        [OUT_W-1:0]  quant_s;

   nn_quantize #(
      .ACC_W      (ACC_W),
      .OUT_W      (OUT_W),
      .FRAC_SHIFT (FRAC_SHIFT),
      .RELU_EN    (RELU_EN)
   ) u_quant (
      .acc_i (cap_q),
      .q_o   (quant_s)
   );

   // Sequencer FSM with registered outputs, capture, arg-max, buffer and read port.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         sel_q         <= '0;
         cap_q         <= '0;
         best_q        <= '0;
         class_idx_q   <= '0;
         class_valid_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         nstart_q      <= 1'b0;
         rd_data_q     <= '0;
         for (int i = 0; i < NUM_NEURONS; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         done_q   <= 1'b0;
         nstart_q <= 1'b0;

         // Reads see the buffer as it stood before this edge's write.
         if (int'(rd_addr) < NUM_NEURONS) begin
            rd_data_q <= buf_q[rd_addr];
         end else begin
            rd_data_q <= '0;
         end

         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  sel_q         <= '0;
                  class_valid_q <= 1'b0;
                  class_idx_q   <= '0;
                  best_q        <= '0;
                  busy_q        <= 1'b1;
                  nstart_q      <= 1'b1;
                  state_q       <= ST_LAUNCH;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_LAUNCH: begin
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               if (neuron_done) begin
                  cap_q   <= neuron_dout;
                  state_q <= ST_STORE;
               end else begin
                  state_q <= ST_WAIT;
               end
            end
            ST_STORE: begin
               buf_q[sel_q] <= quant_s;
               // Strict compare keeps the lower index on ties; neuron 0 seeds it.
               if ((sel_q == '0) || (cap_q > best_q)) begin
                  best_q      <= cap_q;
                  class_idx_q <= sel_q;
               end else begin
                  best_q <= best_q;
               end
               if (sel_q == LAST_SEL) begin
                  done_q  <= 1'b1;
                  state_q <= ST_FINISH;
               end else begin
                  sel_q    <= sel_q + IW'(1);
                  nstart_q <= 1'b1;
                  state_q  <= ST_LAUNCH;
               end
            end
            ST_FINISH: begin
               class_valid_q <= 1'b1;
               busy_q        <= 1'b0;
               state_q       <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign class_idx    = class_idx_q;
   assign class_valid  = class_valid_q;
   assign neuron_start = nstart_q;
   assign neuron_sel   = sel_q;
   assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_layer_sequencer
// Directed bench: two sequencers (ReLU on / ReLU off) share one behavioral
// neuron model that answers each neuron_start after a programmable delay with
// a value from a per-neuron table.
// -----------------------------------------------------------------------------
module tb_layer_sequencer;
   import nn_pkg::*;

   localparam int NN = 10;
   localparam int IW = 4;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [IW-1:0] rd_addr;
   logic          force_done;
   logic [39:0]   force_dout;
   logic          model_done;
   logic [39:0]   model_dout;
   logic          neuron_done;
   logic [39:0]   neuron_dout;

   logic          busy1, done1, class_valid1, neuron_start1;
   logic [IW-1:0] class_idx1, neuron_sel1;
   logic [15:0]   rd_data1;
   logic          busy0, done0, class_valid0, neuron_start0;
   logic [IW-1:0] class_idx0, neuron_sel0;
   logic [15:0]   rd_data0;

   int            errors = 0;
   int            checks = 0;
   int            dly;
   int            c;
   logic [39:0]   vals [NN];

   assign neuron_done = model_done | force_done;
   assign neuron_dout = force_done ? force_dout : model_dout;

   layer_sequencer #(.NUM_NEURONS(NN), .RELU_EN(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy1), .done(done1),
      .class_idx(class_idx1), .class_valid(class_valid1),
      .neuron_start(neuron_start1), .neuron_sel(neuron_sel1),
      .neuron_done(neuron_done), .neuron_dout(neuron_dout),
      .rd_addr(rd_addr), .rd_data(rd_data1)
   );

   layer_sequencer #(.NUM_NEURONS(NN), .RELU_EN(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy0), .done(done0),
      .class_idx(class_idx0), .class_valid(class_valid0),
      .neuron_start(neuron_start0), .neuron_sel(neuron_sel0),
      .neuron_done(neuron_done), .neuron_dout(neuron_dout),
      .rd_addr(rd_addr), .rd_data(rd_data0)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Neuron model: done is high in the dly-th cycle after the launch cycle.
   initial begin
      int cnt;
      cnt        = 0;
      model_done = 1'b0;
      model_dout = 40'h0;
      forever begin
         @(negedge clk);
         model_done = 1'b0;
         if (neuron_start1) begin
            cnt = dly;
         end else if (cnt > 0) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
               model_done = 1'b1;
               model_dout = vals[neuron_sel1];
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_layer();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int lim, output int cyc);
      cyc = 1;
      while (done1 !== 1'b1 && cyc < lim) begin
         tick();
         cyc++;
      end
   endtask

   task automatic rd_chk(input string tag, input int addr, input logic [15:0] e1, input logic [15:0] e0);
      rd_addr = 4'(addr);
      tick();
      chk({tag, "_relu"}, 64'(rd_data1), 64'(e1));
      chk({tag, "_lin"},  64'(rd_data0), 64'(e0));
   endtask

   initial begin
      rst_n      = 1'b0;
      start      = 1'b0;
      rd_addr    = '0;
      force_done = 1'b0;
      force_dout = 40'h0;
      dly        = 5;
      for (int k = 0; k < NN; k++) vals[k] = 40'h0;

      // Reset state
      repeat (3) tick();
      chk("rst_busy",   64'(busy1),         64'd0);
      chk("rst_done",   64'(done1),         64'd0);
      chk("rst_cvalid", 64'(class_valid1),  64'd0);
      chk("rst_nstart", 64'(neuron_start1), 64'd0);
      chk("rst_sel",    64'(neuron_sel1),   64'd0);
      chk("rst_cidx",   64'(class_idx1),    64'd0);
      chk("rst_rdata",  64'(rd_data1),      64'd0);
      rst_n = 1'b1;
      tick();

      // Nominal layer, D = 5: 1.5 for neuron 0, 0.25*k otherwise
      for (int k = 0; k < NN; k++) vals[k] = (k == 0) ? 40'h0000018000 : 40'(k) * 40'h0000004000;
      dly     = 5;
      rd_addr = 4'd3;
      start_layer();
      chk("nom_busy_t1",   64'(busy1),         64'd1);
      chk("nom_nstart_t1", 64'(neuron_start1), 64'd1);
      chk("nom_sel_t1",    64'(neuron_sel1),   64'd0);
      c = 1;
      while (done1 !== 1'b1 && c < 500) begin
         tick();
         c++;
         if (c == 28) chk("nom_sel_store3", 64'(neuron_sel1), 64'd3);
         if (c == 29) chk("nom_rd3_before", 64'(rd_data1), 64'h0000);
         if (c == 30) chk("nom_rd3_after",  64'(rd_data1), 64'h00C0);
      end
      chk("nom_latency",   64'(c),     64'd71);
      chk("nom_done_fin",  64'(done1), 64'd1);
      chk("nom_busy_fin",  64'(busy1), 64'd1);
      tick();
      chk("nom_done_post",   64'(done1),        64'd0);
      chk("nom_busy_post",   64'(busy1),        64'd0);
      chk("nom_cvalid_post", 64'(class_valid1), 64'd1);
      chk("nom_cidx",        64'(class_idx1),   64'd9);
      rd_addr = 4'd0;
      tick();
      chk("nom_buf0", 64'(rd_data1), 64'h0180);
      rd_addr = 4'd1;
      #1;
      chk("rd_latency_hold", 64'(rd_data1), 64'h0180);
      tick();
      chk("rd_latency_new", 64'(rd_data1), 64'h0040);
      rd_chk("nom_buf9", 9, 16'h0240, 16'h0240);
      rd_chk("rd_oob12", 12, 16'h0000, 16'h0000);

      // Spurious neuron_done in IDLE must not write
      force_dout = 40'h0012340000;
      force_done = 1'b1;
      tick();
      force_done = 1'b0;
      chk("idle_done_busy", 64'(busy1), 64'd0);
      rd_chk("idle_done_buf0", 0, 16'h0180, 16'h0180);

      // Sign / ReLU and raw arg-max, D = 2
      for (int k = 0; k < NN; k++) vals[k] = 40'hFFFFFF0000;
      vals[0] = 40'hFFFFFE0000;
      vals[3] = 40'hFFFFFF8000;
      dly = 2;
      start_layer();
      wait_done(500, c);
      chk("sign_latency", 64'(c), 64'd41);
      tick();
      chk("sign_cidx_relu", 64'(class_idx1), 64'd3);
      chk("sign_cidx_lin",  64'(class_idx0), 64'd3);
      rd_chk("sign_buf0", 0, 16'h0000, 16'hFE00);
      rd_chk("sign_buf3", 3, 16'h0000, 16'hFF80);
      rd_chk("sign_buf5", 5, 16'h0000, 16'hFF00);

      // Saturation, ties, start during WAIT, done during LAUNCH, D = 3
      vals[0] = 40'hFFFED40000;
      vals[1] = 40'h0100000000;
      vals[2] = 40'h0200000000;
      vals[3] = 40'h00007FFE00;
      vals[4] = 40'h0000800000;
      vals[5] = 40'hFFFF800000;
      vals[6] = 40'h0200000000;
      vals[7] = 40'hFFFF7FFF00;
      vals[8] = 40'h0000010000;
      vals[9] = 40'h0000010000;
      dly = 3;
      start_layer();
      force_done = 1'b1;
      c = 1;
      while (done1 !== 1'b1 && c < 500) begin
         tick();
         c++;
         if (c == 2) force_done = 1'b0;
         if (c == 4) start = 1'b1;
         if (c == 5) start = 1'b0;
         if (c == 6) chk("sat_sel_n1", 64'(neuron_sel1), 64'd1);
      end
      chk("sat_latency", 64'(c), 64'd51);
      tick();
      chk("tie_cidx_relu", 64'(class_idx1), 64'd2);
      chk("tie_cidx_lin",  64'(class_idx0), 64'd2);
      rd_chk("sat_buf0", 0, 16'h0000, 16'h8000);
      rd_chk("sat_buf1", 1, 16'h7FFF, 16'h7FFF);
      rd_chk("sat_buf3", 3, 16'h7FFE, 16'h7FFE);
      rd_chk("sat_buf4", 4, 16'h7FFF, 16'h7FFF);
      rd_chk("sat_buf5", 5, 16'h0000, 16'h8000);
      rd_chk("sat_buf7", 7, 16'h0000, 16'h8000);
      rd_chk("sat_buf8", 8, 16'h0100, 16'h0100);

      // Back-to-back: start held through FINISH, D = 1
      for (int k = 0; k < NN; k++) vals[k] = 40'(9 - k) * 40'h0000010000;
      dly   = 1;
      start = 1'b1;
      tick();
      chk("b2b_nstart_t1", 64'(neuron_start1), 64'd1);
      wait_done(500, c);
      chk("b2b_latency1", 64'(c), 64'd31);
      tick();
      chk("b2b_busy_idle",   64'(busy1),         64'd0);
      chk("b2b_nstart_idle", 64'(neuron_start1), 64'd0);
      chk("b2b_cvalid_idle", 64'(class_valid1),  64'd1);
      chk("b2b_cidx1",       64'(class_idx1),    64'd0);
      tick();
      chk("b2b_nstart2", 64'(neuron_start1), 64'd1);
      chk("b2b_busy2",   64'(busy1),         64'd1);
      chk("b2b_cvalid2", 64'(class_valid1),  64'd0);
      start = 1'b0;
      wait_done(500, c);
      chk("b2b_latency2", 64'(c), 64'd31);
      tick();
      chk("b2b_cidx2", 64'(class_idx1), 64'd0);
      rd_chk("b2b_buf0", 0, 16'h0900, 16'h0900);

      // Reset during WAIT of neuron 4, D = 5
      for (int k = 0; k < NN; k++) vals[k] = 40'(k + 1) * 40'h0000004000;
      dly = 5;
      start_layer();
      c = 1;
      while (c < 31) begin
         tick();
         c++;
      end
      chk("mid_sel4", 64'(neuron_sel1), 64'd4);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_busy",   64'(busy1),         64'd0);
      chk("mid_rst_cvalid", 64'(class_valid1),  64'd0);
      chk("mid_rst_nstart", 64'(neuron_start1), 64'd0);
      chk("mid_rst_sel",    64'(neuron_sel1),   64'd0);
      chk("mid_rst_cidx",   64'(class_idx1),    64'd0);
      chk("mid_rst_rdata",  64'(rd_data0),      64'd0);
      rst_n = 1'b1;
      repeat (6) tick();
      chk("late_done_busy", 64'(busy1), 64'd0);
      chk("late_done_done", 64'(done1), 64'd0);
      for (int k = 0; k < NN; k++) rd_chk($sformatf("mid_rst_buf%0d", k), k, 16'h0000, 16'h0000);

      // Fresh layer after reset, D = 2: k * 1.0
      for (int k = 0; k < NN; k++) vals[k] = 40'(k) * 40'h0000010000;
      dly = 2;
      start_layer();
      wait_done(500, c);
      chk("fresh_latency", 64'(c), 64'd41);
      tick();
      chk("fresh_cvalid", 64'(class_valid1), 64'd1);
      chk("fresh_cidx",   64'(class_idx1),   64'd9);
      rd_chk("fresh_buf5", 5, 16'h0500, 16'h0500);
      rd_chk("fresh_buf0", 0, 16'h0000, 16'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
